collision_scheduler: RTL and testbench
======================================

Name: collision_scheduler

Overview:
- Sequences one collision pass over the lattice held in BRAM.
- Sweeps cell addresses 0..NUM_CELLS-1, reads each cell's 9 densities, presents them to the collision datapath, and writes each result back to the address it was read from.
- Buffers in-flight addresses in a small FIFO so that collision results can be matched to their cells.
- Sits between the frame sequencer (start/done), BRAM (read port A, write port B) and the collision block.

Parameters:
- NUM_CELLS, 16384, cells per pass.
- ADDR_WIDTH, 14, BRAM address width; must satisfy 2**ADDR_WIDTH >= NUM_CELLS.
- READ_LATENCY, 2, cycles from rd_en_out to valid rd_data_in.
- ISSUE_GAP, 1, minimum cycles between successive issues; 1 means back-to-back.
- MAX_OUTSTANDING, 4, maximum issued-but-not-written cells; also the address FIFO depth; power of 2.
- TIMEOUT_CYCLES, 64, watchdog limit (optional feature only).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- start_in  in  1  pulse: begin a pass; ignored unless idle
- busy_out  out  1  high from accepted start until frame_done_out
- frame_done_out  out  1  one-cycle pulse when the last write-back has been issued
- rd_en_out  out  1  BRAM read strobe
- rd_addr_out  out  ADDR_WIDTH  BRAM read address
- rd_data_in  in  72  9x8-bit densities, valid READ_LATENCY cycles after rd_en_out
- coll_data_out  out  72  to collision data_in
- coll_valid_out  out  1  to collision data_valid_in
- coll_result_in  in  72  from collision data_out
- coll_done_in  in  1  from collision done_colliding_out
- wr_en_out  out  1  BRAM write strobe
- wr_addr_out  out  ADDR_WIDTH  BRAM write address
- wr_data_out  out  72  BRAM write data
- protocol_err_out  out  1  sticky error flag
- outstanding_out  out  $clog2(MAX_OUTSTANDING)+1  current in-flight count

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; address counter 0; gap counter 0.
- Reset asserted mid-pass aborts the pass immediately. No further reads or writes occur, and frame_done_out is not pulsed.
- States:
  - IDLE: start_in=1 goes to ISSUE; busy_out goes to 1 next cycle.
  - ISSUE: issue a cell when outstanding < MAX_OUTSTANDING and the gap counter is 0. An issue drives rd_en_out=1 with rd_addr_out = address counter, pushes the address into the FIFO, increments the counter, and reloads the gap counter with ISSUE_GAP-1. After issuing address NUM_CELLS-1, go to DRAIN.
  - DRAIN: no issues. When outstanding reaches 0, go to DONE.
  - DONE: frame_done_out=1 for one cycle; busy_out=0 in the same cycle; go to IDLE.
- Read path:
  - rd_en_out is delayed through a READ_LATENCY-stage shift register to produce coll_valid_out.
  - coll_data_out = rd_data_in, combinational.
  - Read-to-collide latency is exactly READ_LATENCY cycles.
- Write-back:
  - On coll_done_in=1 with the FIFO non-empty: pop the FIFO head.
  - Next cycle: wr_en_out=1, wr_addr_out = popped address, wr_data_out = coll_result_in registered in the done cycle.
  - Write order equals issue order.
- outstanding: +1 on issue, -1 on pop. An issue and a pop in the same cycle leave it unchanged. It never exceeds MAX_OUTSTANDING.
- coll_done_in with the FIFO empty (spurious): ignored for writes; sets protocol_err_out, which is cleared only by reset.
- start_in while busy: ignored. start_in in the DONE cycle: ignored.
- NUM_CELLS=1: a single issue, then DRAIN.
- The address counter does not wrap within a pass; it resets to 0 on each accepted start.

Optional Feature:
- Macro: COLLISION_SCHED_TIMEOUT_EN.
- With the macro:
  - A watchdog counts cycles while outstanding > 0 with no pop, and clears on each pop.
  - Reaching TIMEOUT_CYCLES sets protocol_err_out, flushes the FIFO, zeroes outstanding, and goes to DONE. frame_done_out still pulses, so the frame sequencer never hangs.
  - Results arriving later are treated as spurious.
- Without the macro: no watchdog; the scheduler waits indefinitely in ISSUE/DRAIN.

Test Plan:
1. NUM_CELLS=4, READ_LATENCY=2, ISSUE_GAP=1, collision model with fixed 20-cycle latency and result = data+1 per byte; pulse start.
   -> Reads at addresses 0,1,2,3 are issued only while outstanding < MAX_OUTSTANDING.
   -> Writes go to 0,1,2,3 in order with incremented data.
   -> frame_done_out pulses once the cycle after the last write; busy_out falls with it.
2. MAX_OUTSTANDING=2, model latency 20.
   -> outstanding_out never exceeds 2.
   -> The third read waits until the first write-back.
3. Issue and pop coinciding in one cycle.
   -> outstanding_out holds its value.
   -> The FIFO address order is preserved.
4. Inject coll_done_in while idle.
   -> No wr_en_out.
   -> protocol_err_out=1 and stays 1 until rst_in.
5. Assert rst_in for 1 cycle while 3 cells are in flight.
   -> All outputs are 0 the next cycle; no writes follow; a new start runs a clean pass from address 0.
6. With COLLISION_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=64, the model never returns done.
   -> 64 cycles after the first issue, protocol_err_out=1 and frame_done_out pulses.
   -> busy_out=0; the state returns to IDLE.

Source files
------------

// File: rtl/collision_scheduler.sv
// ---------------------------------------------------------------------------
// collision_scheduler
//
// Runs one collision pass over the lattice stored in BRAM. Cell addresses
// 0..NUM_CELLS-1 are read in order through port A. Each read word goes to the
// collision datapath. The cell address is remembered in a small FIFO. Each
// collision result is written back through port B to the address it came from.
//
// Ports:
//   clk_in            system clock
//   rst_in            synchronous active-high reset
//   start_in          pulse, begins a pass (accepted only when idle)
//   busy_out          high from accepted start until frame_done_out
//   frame_done_out    one-cycle pulse after the last write-back is issued
//   rd_en_out         BRAM read strobe
//   rd_addr_out       BRAM read address
//   rd_data_in        9x8-bit densities, valid READ_LATENCY cycles after rd_en_out
//   coll_data_out     densities to the collision block (rd_data_in, combinational)
//   coll_valid_out    rd_en_out delayed by READ_LATENCY cycles
//   coll_result_in    collision result
//   coll_done_in      collision result valid
//   wr_en_out         BRAM write strobe
//   wr_addr_out       BRAM write address
//   wr_data_out       BRAM write data
//   protocol_err_out  sticky error flag (spurious done, or watchdog expiry)
//   outstanding_out   number of issued cells not yet popped for write-back
//
// Optional feature: define COLLISION_SCHED_TIMEOUT_EN to enable a watchdog.
// The watchdog ends the pass when no result has come back for
// TIMEOUT_CYCLES cycles while cells are outstanding.
// ---------------------------------------------------------------------------
module collision_scheduler #(
  parameter int NUM_CELLS       = 16384,
  parameter int ADDR_WIDTH      = 14,
  parameter int READ_LATENCY    = 2,
  parameter int ISSUE_GAP       = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 start_in,
  output logic                                 busy_out,
  output logic                                 frame_done_out,
  output logic                                 rd_en_out,
  output logic [ADDR_WIDTH-1:0]                rd_addr_out,
  input  logic [71:0]                          rd_data_in,
  output logic [71:0]                          coll_data_out,
  output logic                                 coll_valid_out,
  input  logic [71:0]                          coll_result_in,
  input  logic                                 coll_done_in,
  output logic                                 wr_en_out,
  output logic [ADDR_WIDTH-1:0]                wr_addr_out,
  output logic [71:0]                          wr_data_out,
  output logic                                 protocol_err_out,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_out
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_CELLS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [OUT_W-1:0]      MAX_OUT    = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0]      OUT_ONE    = OUT_W'(1);
  localparam logic [GAP_W-1:0]      GAP_RELOAD = GAP_W'(ISSUE_GAP - 1);
  localparam logic [GAP_W-1:0]      GAP_ONE    = GAP_W'(1);
  localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    frame_done_q, frame_done_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [71:0]             wr_data_q, wr_data_d;
  logic                    err_q, err_d;
  logic [OUT_W-1:0]        outst_q, outst_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0]   fifo_q [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0]   fifo_d [MAX_OUTSTANDING];

  logic issue_s;
  logic pop_s;
  logic spurious_s;
  logic timeout_s;

`ifdef COLLISION_SCHED_TIMEOUT_EN
  localparam int                WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_ONE   = WD_W'(1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_run_s;

  // Watchdog: counts stalled cycles while cells are outstanding and no result returns.
  always_comb begin
    wd_run_s  = (outst_q != {OUT_W{1'b0}}) && !pop_s;
    timeout_s = wd_run_s && (wd_q == WD_LIMIT);
    if (wd_run_s && !timeout_s) begin
      wd_d = wd_q + WD_ONE;
    end else begin
      wd_d = {WD_W{1'b0}};
    end
  end
`else
  // Without the watchdog a pass waits indefinitely for its results.
  always_comb begin
    timeout_s = 1'b0;
  end
`endif

  // Issue/pop decisions. The FIFO occupancy always equals outst_q.
  always_comb begin
    issue_s    = (state_q == S_ISSUE) && (outst_q < MAX_OUT) &&
                 (gap_q == {GAP_W{1'b0}}) && !timeout_s;
    pop_s      = coll_done_in && (outst_q != {OUT_W{1'b0}});
    spurious_s = coll_done_in && (outst_q == {OUT_W{1'b0}});
  end

  // Next-state logic for the FSM, issue counters, FIFO and write-back registers.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    rd_en_d      = issue_s;
    rd_addr_d    = rd_addr_q;
    addr_d       = addr_q;
    gap_d        = gap_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_d       = fifo_q;
    wr_en_d      = pop_s;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    err_d        = err_q | spurious_s | timeout_s;

    // Read pipeline: coll_valid_out is rd_en_out delayed READ_LATENCY cycles.
    rd_pipe_d[0] = rd_en_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end

    // Issue: read strobe, address into the FIFO, advance the counter, reload the gap.
    // The counter stops on the last cell so it never wraps within a pass.
    if (issue_s) begin
      rd_addr_d          = addr_q;
      fifo_d[wr_ptr_q]   = addr_q;
      wr_ptr_d           = wr_ptr_q + PTR_ONE;
      gap_d              = GAP_RELOAD;
      if (addr_q != LAST_ADDR) begin
        addr_d = addr_q + ADDR_ONE;
      end else begin
        addr_d = addr_q;
      end
    end else if (gap_q != {GAP_W{1'b0}}) begin
      gap_d = gap_q - GAP_ONE;
    end else begin
      gap_d = gap_q;
    end

    // Write-back: the FIFO head pairs with the result returned in this cycle.
    if (pop_s) begin
      wr_addr_d = fifo_q[rd_ptr_q];
      wr_data_d = coll_result_in;
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
    end else begin
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end

    // In-flight count; a simultaneous issue and pop cancel out.
    case ({issue_s, pop_s})
      2'b10:   outst_d = outst_q + OUT_ONE;
      2'b01:   outst_d = outst_q - OUT_ONE;
      default: outst_d = outst_q;
    endcase

    // Watchdog expiry drops every in-flight cell. Results that arrive later are spurious.
    if (timeout_s) begin
      outst_d  = {OUT_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
    end else begin
      outst_d  = outst_d;
    end

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d = S_ISSUE;
          busy_d  = 1'b1;
          addr_d  = {ADDR_WIDTH{1'b0}};
          gap_d   = {GAP_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (timeout_s) begin
          state_d      = S_DONE;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end else if (issue_s && (addr_q == LAST_ADDR)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (timeout_s || (outst_q == {OUT_W{1'b0}})) begin
          state_d      = S_DONE;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        // start_in is deliberately not looked at here.
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset aborts any pass in progress.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= {ADDR_WIDTH{1'b0}};
      rd_pipe_q    <= {READ_LATENCY{1'b0}};
      wr_en_q      <= 1'b0;
      wr_addr_q    <= {ADDR_WIDTH{1'b0}};
      wr_data_q    <= {72{1'b0}};
      err_q        <= 1'b0;
      outst_q      <= {OUT_W{1'b0}};
      addr_q       <= {ADDR_WIDTH{1'b0}};
      gap_q        <= {GAP_W{1'b0}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= {ADDR_WIDTH{1'b0}};
      end
`ifdef COLLISION_SCHED_TIMEOUT_EN
      wd_q         <= {WD_W{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      rd_pipe_q    <= rd_pipe_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      err_q        <= err_d;
      outst_q      <= outst_d;
      addr_q       <= addr_d;
      gap_q        <= gap_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_q       <= fifo_d;
`ifdef COLLISION_SCHED_TIMEOUT_EN
      wd_q         <= wd_d;
`endif
    end
  end

  assign busy_out         = busy_q;
  assign frame_done_out   = frame_done_q;
  assign rd_en_out        = rd_en_q;
  assign rd_addr_out      = rd_addr_q;
  assign coll_data_out    = rd_data_in;
  assign coll_valid_out   = rd_pipe_q[READ_LATENCY-1];
  assign wr_en_out        = wr_en_q;
  assign wr_addr_out      = wr_addr_q;
  assign wr_data_out      = wr_data_q;
  assign protocol_err_out = err_q;
  assign outstanding_out  = outst_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// ---------------------------------------------------------------------------
// tb_collision_scheduler
//
// Scoreboard bench for collision_scheduler. The DUT has 6 cells and a
// 2-deep in-flight window. The collision model has a 20-cycle latency and
// adds 1 to every byte. Starting a pass loads the expected reads and
// write-backs into queues. The monitor pops those queues whenever the DUT
// presents a read, a collision word, a write or frame_done. It also tracks
// the in-flight count independently from the observed strobes.
// ---------------------------------------------------------------------------
module tb_collision_scheduler;

  localparam int NC = 6;
  localparam int AW = 4;
  localparam int RL = 2;
  localparam int GP = 1;
  localparam int MO = 2;
  localparam int TO = 64;
  localparam int CL = 20;
  localparam int OW = $clog2(MO) + 1;

  logic          clk;
  logic          rst_in;
  logic          start_in;
  logic          busy_out;
  logic          frame_done_out;
  logic          rd_en_out;
  logic [AW-1:0] rd_addr_out;
  logic [71:0]   rd_data_in;
  logic [71:0]   coll_data_out;
  logic          coll_valid_out;
  logic [71:0]   coll_result_in;
  logic          coll_done_in;
  logic          wr_en_out;
  logic [AW-1:0] wr_addr_out;
  logic [71:0]   wr_data_out;
  logic          protocol_err_out;
  logic [OW-1:0] outstanding_out;

  collision_scheduler #(
    .NUM_CELLS(NC), .ADDR_WIDTH(AW), .READ_LATENCY(RL),
    .ISSUE_GAP(GP), .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
    .busy_out(busy_out), .frame_done_out(frame_done_out),
    .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in),
    .coll_data_out(coll_data_out), .coll_valid_out(coll_valid_out),
    .coll_result_in(coll_result_in), .coll_done_in(coll_done_in),
    .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .protocol_err_out(protocol_err_out), .outstanding_out(outstanding_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] inc_bytes(input logic [71:0] d);
    logic [71:0] r;
    for (int j = 0; j < 9; j++) r[j*8 +: 8] = d[j*8 +: 8] + 8'd1;
    return r;
  endfunction

  // BRAM contents and a 2-cycle read port model
  logic [71:0] mem [NC];
  logic [71:0] p1, p2;
  initial begin
    p1 = 72'h0;
    p2 = 72'h0;
  end
  always @(posedge clk) begin
    p1 <= rd_en_out ? mem[rd_addr_out] : 72'h0;
    p2 <= p1;
  end
  assign rd_data_in = p2;

  // Collision block model: fixed latency, per-byte increment, flushed by reset
  logic [72:0] cpipe [CL];
  logic        mute;
  logic        inj_done;
  initial for (int i = 0; i < CL; i++) cpipe[i] = 73'h0;
  always @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < CL; i++) cpipe[i] <= 73'h0;
    end else begin
      cpipe[0] <= {coll_valid_out & ~mute, inc_bytes(coll_data_out)};
      for (int i = 1; i < CL; i++) cpipe[i] <= cpipe[i-1];
    end
  end
  assign coll_done_in   = cpipe[CL-1][72] | inj_done;
  assign coll_result_in = cpipe[CL-1][71:0];

  // Scoreboard
  logic [AW-1:0]    exp_rd_q   [$];
  logic [71:0]      exp_coll_q [$];
  logic [AW+71:0]   exp_wr_q   [$];
  int  exp_outst   = 0;
  int  rd_in_pass  = 0;
  int  wr_in_pass  = 0;
  int  last_wr_cyc = -10;
  int  first_rd_cyc = 0;
  int  done_cnt    = 0;
  int  wr_total    = 0;
  int  cyc         = 0;
  bit  to_mode     = 1'b0;
  logic rst_seen   = 1'b1;

  always @(posedge clk) rst_seen <= rst_in;

  // Monitor: sampled on the falling edge, away from the DUT's active edge
  always @(negedge clk) begin
    cyc++;
    if (rst_seen) begin
      exp_rd_q.delete();
      exp_coll_q.delete();
      exp_wr_q.delete();
      exp_outst  = 0;
      rd_in_pass = 0;
      wr_in_pass = 0;
    end else begin
      if (wr_en_out) begin
        if (exp_wr_q.size() == 0) begin
          check("wr_unexpected", {wr_addr_out, wr_data_out}, 96'h0);
          if ({wr_addr_out, wr_data_out} == 76'h0) check("wr_unexpected_strobe", 96'd1, 96'd0);
        end else begin
          check("wr_addr_data", {wr_addr_out, wr_data_out}, exp_wr_q.pop_front());
        end
        wr_in_pass++;
        wr_total++;
        exp_outst--;
        last_wr_cyc = cyc;
      end
      if (rd_en_out) begin
        if (rd_in_pass == 0) first_rd_cyc = cyc;
        if (exp_rd_q.size() == 0) begin
          check("rd_unexpected", 96'(rd_addr_out) + 96'h100, 96'h0);
        end else begin
          logic [AW-1:0] a;
          a = exp_rd_q.pop_front();
          check("rd_addr", rd_addr_out, a);
          exp_coll_q.push_back(mem[a]);
        end
        check("rd_window", 96'(wr_in_pass >= rd_in_pass + 1 - MO), 96'd1);
        rd_in_pass++;
        exp_outst++;
      end
      if (coll_valid_out) begin
        if (exp_coll_q.size() == 0) check("coll_unexpected", 96'd1, 96'd0);
        else check("coll_data", coll_data_out, exp_coll_q.pop_front());
      end
      if (frame_done_out) begin
        done_cnt++;
        if (to_mode) begin
          check("timeout_latency", 96'(cyc - first_rd_cyc), 96'(TO));
          check("timeout_err", protocol_err_out, 96'd1);
          exp_outst = 0;
          exp_wr_q.delete();
          exp_rd_q.delete();
        end else begin
          check("done_after_last_wr", 96'(cyc - last_wr_cyc), 96'd1);
          check("done_all_written", 96'(exp_wr_q.size()), 96'd0);
        end
        check("busy_low_at_done", busy_out, 96'd0);
        rd_in_pass = 0;
        wr_in_pass = 0;
      end
      check("outstanding", outstanding_out, 96'(exp_outst));
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     busy_out,         96'd0);
    check({tag, "_done"},     frame_done_out,   96'd0);
    check({tag, "_rd_en"},    rd_en_out,        96'd0);
    check({tag, "_rd_addr"},  rd_addr_out,      96'd0);
    check({tag, "_cvalid"},   coll_valid_out,   96'd0);
    check({tag, "_wr_en"},    wr_en_out,        96'd0);
    check({tag, "_wr_addr"},  wr_addr_out,      96'd0);
    check({tag, "_wr_data"},  wr_data_out,      96'd0);
    check({tag, "_err"},      protocol_err_out, 96'd0);
    check({tag, "_outst"},    outstanding_out,  96'd0);
  endtask

  task automatic push_pass();
    for (int i = 0; i < NC; i++) begin
      exp_rd_q.push_back(AW'(i));
      exp_wr_q.push_back({AW'(i), inc_bytes(mem[i])});
    end
  endtask

  task automatic run_pass(input bit poke_busy, input bit poke_done, input int bound);
    int n;
    push_pass();
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    check("busy_after_start", busy_out, 96'd1);
    n = 0;
    while (!frame_done_out && n < bound) begin
      @(negedge clk);
      n++;
      start_in = (poke_busy && n == 4) ? 1'b1 : 1'b0;
    end
    start_in = 1'b0;
    check("frame_done_seen", frame_done_out, 96'd1);
    if (poke_done) start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    check("frame_done_one_cycle", frame_done_out, 96'd0);
    check("busy_after_done", busy_out, 96'd0);
    repeat (3) @(negedge clk);
    check("idle_after_pass", busy_out, 96'd0);
    check("outst_after_pass", outstanding_out, 96'd0);
  endtask

  initial begin
    int n;
    int wr_snap;
    int done_snap;
    rst_in   = 1'b1;
    start_in = 1'b0;
    inj_done = 1'b0;
    mute     = 1'b0;
    for (int i = 0; i < NC; i++)
      for (int j = 0; j < 9; j++)
        mem[i][j*8 +: 8] = 8'(i * 32 + j * 3 + 1);
    mem[NC-1][71:64] = 8'hFF;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_cdata", coll_data_out, 96'd0);
    rst_in = 1'b0;
    @(negedge clk);

    // Normal pass with a start pulse while busy and one in the DONE cycle
    run_pass(1'b1, 1'b1, 1000);
    check("err_clean_pass", protocol_err_out, 96'd0);

    // Spurious done while idle
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (5) @(negedge clk);
    check("spurious_err", protocol_err_out, 96'd1);
    check("spurious_no_wr", 96'(wr_total), 96'(NC));

    // Second pass: error flag stays sticky
    run_pass(1'b0, 1'b0, 1000);
    check("err_sticky", protocol_err_out, 96'd1);

    // Reset while cells are in flight
    push_pass();
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    n = 0;
    while (outstanding_out != OW'(MO) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("inflight_before_reset", outstanding_out, 96'(MO));
    wr_snap   = wr_total;
    done_snap = done_cnt;
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    check_all_zero("abort");
    repeat (60) @(negedge clk);
    check("abort_no_wr", 96'(wr_total), 96'(wr_snap));
    check("abort_no_done", 96'(done_cnt), 96'(done_snap));
    check("abort_idle", busy_out, 96'd0);

    // Clean pass after the abort
    run_pass(1'b0, 1'b0, 1000);
    check("err_after_clean", protocol_err_out, 96'd0);

`ifdef COLLISION_SCHED_TIMEOUT_EN
    // Collision block never answers: the watchdog ends the pass
    mute    = 1'b1;
    to_mode = 1'b1;
    run_pass(1'b0, 1'b0, 300);
    check("timeout_err_sticky", protocol_err_out, 96'd1);
    mute    = 1'b0;
    to_mode = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
